bram_bec: RTL
=============

# bram_bec

Parametrised single-port block RAM with per-byte write masks, registered synchronous read with a valid flag, and a hardware clear engine that sweeps the array after reset or on request. Replaces the single-cycle whole-array reset of the previous RAM so the array maps onto M9K blocks. Sits behind the load/store unit as data memory and is reusable as instruction or scratch memory.

## Interface
- ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration error otherwise)
- CLEAR_VALUE, 0, word written to every location by the clear sweep
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  access request; accepted when i_req && o_ready
- i_we  in  1  1 = write, 0 = read (qualified by i_req)
- i_addr  in  ADDR_WIDTH  word address
- i_wdata  in  DATA_WIDTH  write data
- i_bmask  in  DATA_WIDTH/8  byte-lane write enables, bit n covers bits [8n+7:8n]
- i_clear  in  1  start clear sweep (pulse)
- o_ready  out  1  block idle, accepting requests
- o_busy  out  1  clear sweep in progress
- o_rdata  out  DATA_WIDTH  read data
- o_rvalid  out  1  o_rdata holds data of an accepted read (one-cycle pulse)

## Operation
- FSM: CLEAR, IDLE. o_busy = (state==CLEAR), o_ready = (state==IDLE).
- Reset: state CLEAR, sweep pointer 0, o_rvalid 0, o_rdata 0, pipeline registers 0. Reset mid-sweep restarts from address 0.
- CLEAR: each cycle writes CLEAR_VALUE (all lanes) to pointer, pointer += 1; after writing DEPTH-1 go IDLE. i_req and i_clear ignored (not accepted, no side effects).
- IDLE: accepted write updates only lanes with i_bmask bit set; i_bmask = 0 is a legal no-op write. Accepted read produces o_rvalid. i_clear → CLEAR next cycle.
- i_clear with accepted i_req in same IDLE cycle: request executes; sweep starts next cycle. A read accepted on the last IDLE cycle still returns o_rvalid on schedule (returns pre-clear data).
- Read and write to same address never coincide (single port); back-to-back write then read of same address returns new data.
- Writes produce no o_rvalid. o_rdata holds its last value when o_rvalid is 0.
- Pointer width ADDR_WIDTH+1 internally; terminal compare on DEPTH-1, no wrap.

## Timing
- Read latency: 1 cycle (read accepted at edge N → o_rvalid/o_rdata valid after edge N+1); 2 cycles with output register enabled.
- Write visible to a read accepted on the following edge.
- Full throughput: one access per cycle in IDLE, no bubbles.
- Clear duration: exactly DEPTH cycles; o_ready rises DEPTH edges after the first edge with i_reset low, or DEPTH+1 edges after the edge sampling i_clear.

## Configuration
- BRAM_BEC_OUTREG_EN defined: extra register on o_rdata/o_rvalid, read latency 2, better Fmax; register resets to 0.
- Undefined: o_rdata driven directly by the array read register, latency 1.

## Structure
- bram_pkg: bram_state_e (CLEAR, IDLE), lane-count function DATA_WIDTH/8, latency constant derived from BRAM_BEC_OUTREG_EN.
- Sub-module bram_bec_array: pure storage with byte-lane write and registered read, no reset on the array, `ramstyle` M9K attribute; FSM and clear mux live in bram_bec.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=32, CLEAR_VALUE=0: release reset → o_busy 1 for 16 cycles, o_ready 1 on 16th edge; read all 16 addresses → all 0x00000000.
- Write 0xDEADBEEF to addr 3 mask 4'b1111, then 0x11223344 mask 4'b0101 → read addr 3 = 0xDE22BE44, o_rvalid one cycle after accept.
- Back-to-back reads addr 0..15 after writing addr value = addr*0x01010101 → 16 consecutive o_rvalid pulses, correct data, no gaps.
- i_clear with read of addr 3 in same cycle → read returns 0xDE22BE44, then 16 busy cycles; requests during sweep ignored; addr 3 then reads 0.
- Assert i_reset at sweep pointer 7 → sweep restarts at 0, o_ready after 16 more cycles; o_rdata and o_rvalid 0 during reset.
- Build with BRAM_BEC_OUTREG_EN → same checks with latency 2.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared state type, lane helper and read-latency constant for bram_bec.
// Optional feature macro: BRAM_BEC_OUTREG_EN. When defined, an extra output
// register is added on o_rdata/o_rvalid and the read latency becomes 2.
package bram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } bram_state_e;

   // number of byte lanes in a word
   function automatic int lane_count(input int data_width);
      return data_width / 8;
   endfunction

`ifdef BRAM_BEC_OUTREG_EN
   localparam int READ_LATENCY = 2;
`else
   localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_bec_array.sv
// bram_bec_array: pure storage for bram_bec. Byte-lane writes and a registered
// read. The array itself has no reset so it maps onto M9K blocks; only the read
// data register is cleared by reset.
module bram_bec_array
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_we,
   input  logic                    i_re,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_bmask,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int LANES = lane_count(DATA_WIDTH);

   (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // byte-lane write, only lanes with their mask bit set are touched
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (i_we && i_bmask[i]) begin
            mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   // registered read, loaded only on an accepted read so it holds otherwise
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= mem[i_addr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/bram_bec.sv
// bram_bec: single-port block RAM with per-byte write masks, registered read
// with valid flag, and a clear engine that sweeps CLEAR_VALUE through the array
// after reset or on i_clear.
// Optional feature macro: BRAM_BEC_OUTREG_EN (output register, read latency 2;
// selected through bram_pkg::READ_LATENCY).
//
// state | meaning
// CLEAR | sweeping CLEAR_VALUE into every word, requests and i_clear ignored
// IDLE  | accepting one read or write per cycle, i_clear starts a new sweep
module bram_bec
   import bram_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 9,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_req,
   input  logic                    i_we,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_bmask,
   input  logic                    i_clear,
   output logic                    o_ready,
   output logic                    o_busy,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_rvalid
);

   localparam int                DEPTH    = 2**ADDR_WIDTH;
   localparam int                LANES    = lane_count(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

   if (DATA_WIDTH % 8 != 0) begin : g_width_check
      $error("bram_bec: DATA_WIDTH must be a multiple of 8");
   end

   bram_state_e             state;
   logic [ADDR_WIDTH:0]     ptr;
   logic                    rvalid_a;
   logic [DATA_WIDTH-1:0]   rdata_a;

   logic                    in_clear;
   logic                    accept_rd;
   logic                    accept_wr;
   logic                    arr_we;
   logic [ADDR_WIDTH-1:0]   arr_addr;
   logic [DATA_WIDTH-1:0]   arr_wdata;
   logic [LANES-1:0]        arr_bmask;

   assign in_clear  = (state == CLEAR);
   assign accept_rd = (state == IDLE) && i_req && !i_we;
   assign accept_wr = (state == IDLE) && i_req && i_we;

   // the sweep owns the port while clearing; the request path owns it otherwise
   always_comb begin
      arr_we    = accept_wr;
      arr_addr  = i_addr;
      arr_wdata = i_wdata;
      arr_bmask = i_bmask;
      if (in_clear) begin
         arr_we    = 1'b1;
         arr_addr  = ptr[ADDR_WIDTH-1:0];
         arr_wdata = CLEAR_VALUE;
         arr_bmask = '1;
      end
   end

   // sweep sequencing and read-valid tracking
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= CLEAR;
         ptr      <= '0;
         rvalid_a <= 1'b0;
      end else begin
         rvalid_a <= accept_rd;
         case (state)
            CLEAR: begin
               if (ptr == PTR_LAST) begin
                  state <= IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            IDLE: begin
               if (i_clear) begin
                  state <= CLEAR;
                  ptr   <= '0;
               end
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   bram_bec_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (arr_we),
      .i_re    (accept_rd),
      .i_addr  (arr_addr),
      .i_wdata (arr_wdata),
      .i_bmask (arr_bmask),
      .o_rdata (rdata_a)
   );

   if (READ_LATENCY > 1) begin : g_outreg
      logic                  rvalid_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      // output retiming stage; data only moves with a valid so it holds otherwise
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
         end else begin
            rvalid_q <= rvalid_a;
            if (rvalid_a) begin
               rdata_q <= rdata_a;
            end
         end
      end

      assign o_rvalid = rvalid_q;
      assign o_rdata  = rdata_q;
   end else begin : g_direct
      assign o_rvalid = rvalid_a;
      assign o_rdata  = rdata_a;
   end

   assign o_busy  = in_clear;
   assign o_ready = (state == IDLE);

endmodule
